// File: rtl/rv32im_csr_unit_pkg.sv
// rtl/rv32im_csr_unit_pkg.sv - shared encodings, FSM states and legality helpers for the CSR unit
package rv32im_csr_unit_pkg;

  localparam int API_XLEN  = 32;
  localparam int CSR_WIDTH = 12;

  // Zicsr funct3 encodings
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Privilege encodings
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } csr_state_e;

  // RW forms always write; set/clear forms write only with a non-zero rs1/zimm.
  function automatic logic csr_write_intent(input logic [1:0] f3_op, input logic [4:0] rs1_idx);
    return (f3_op == 2'b01) || (rs1_idx != 5'd0);
  endfunction

  // addr_hi is csr_addr[11:8]: [3:2] read-only marker, [1:0] minimum privilege.
  function automatic logic csr_illegal(input logic [1:0] f3_op, input logic [3:0] addr_hi,
                                       input logic [1:0] priv, input logic wr_intent);
    return (f3_op == 2'b00) || (priv < addr_hi[1:0]) || (wr_intent && (addr_hi[3:2] == 2'b11));
  endfunction

endpackage

// File: rtl/rv32im_csr_alu.sv
// rtl/rv32im_csr_alu.sv - combinational new-value computation for CSRRW/RS/RC and immediate forms
// Ports: funct3_i (instruction funct3), old_i (current CSR value), operand_i (rs1 value or zimm),
//        new_o (value to write back).
module rv32im_csr_alu
  import rv32im_csr_unit_pkg::*;
#(
  parameter int XLEN = API_XLEN
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = old_i;
    case (funct3_i)
      F3_CSRRW, F3_CSRRWI: new_o = operand_i;
      F3_CSRRS, F3_CSRRSI: new_o = old_i | operand_i;
      F3_CSRRC, F3_CSRRCI: new_o = old_i & ~operand_i;
      default:             new_o = old_i;
    endcase
  end

endmodule

// File: rtl/rv32im_csr_unit.sv
// rtl/rv32im_csr_unit.sv - sequences Zicsr read-modify-write on the CSR regfile port
// Ports: req_* (request handshake from execute: funct3, CSR address, rs1 index/zimm, rs1 value,
//        privilege), csr_* (regfile read/write port), resp_* (result handshake: old value in
//        rd_val_o, illegal_o exception flag). All outputs are registered.
module rv32im_csr_unit
  import rv32im_csr_unit_pkg::*;
#(
  parameter int XLEN   = API_XLEN,
  parameter int CSR_AW = CSR_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [XLEN-1:0]   rs1_val_i,
  input  logic [1:0]        priv_mode_i,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              csr_read_en_o,
  output logic              csr_write_en_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   rd_val_o,
  output logic              illegal_o
);

  csr_state_e r_state, w_state_nxt;

  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_operand;
  logic            r_wr_intent;
  logic [XLEN-1:0] r_old;

  logic            w_accept, w_wr_intent, w_illegal;
  logic [XLEN-1:0] w_operand, w_alu_new;

  logic              w_req_ready_nxt, w_read_en_nxt, w_write_en_nxt, w_resp_valid_nxt, w_illegal_nxt;
  logic [CSR_AW-1:0] w_addr_nxt;
  logic [XLEN-1:0]   w_wdata_nxt, w_rd_val_nxt;

  assign w_accept    = req_valid_i && req_ready_o;
  assign w_operand   = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_val_i;
  assign w_wr_intent = csr_write_intent(funct3_i[1:0], rs1_idx_i);
  assign w_illegal   = csr_illegal(funct3_i[1:0], csr_addr_i[11:8], priv_mode_i, w_wr_intent);

  // The regfile returns the old value during CAPTURE, so the ALU works on it directly.
  rv32im_csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3_i  (r_funct3),
    .old_i     (csr_rdata_i),
    .operand_i (r_operand),
    .new_o     (w_alu_new)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = w_illegal ? ST_RESP : ST_READ;
      ST_READ:    w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = r_wr_intent ? ST_WRITE : ST_RESP;
      ST_WRITE:   w_state_nxt = ST_RESP;
      ST_RESP:    if (resp_ready_i) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, registered below so every output is a flop.
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_read_en_nxt    = (w_state_nxt == ST_READ);
    w_write_en_nxt   = (w_state_nxt == ST_WRITE);
    w_resp_valid_nxt = (w_state_nxt == ST_RESP);
    w_addr_nxt       = csr_addr_o;
    w_wdata_nxt      = csr_wdata_o;
    w_rd_val_nxt     = '0;
    w_illegal_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_illegal) w_addr_nxt = csr_addr_i;
        if (w_accept && w_illegal)  w_illegal_nxt = 1'b1;
      end
      ST_CAPTURE: begin
        if (r_wr_intent) w_wdata_nxt  = w_alu_new;
        else             w_rd_val_nxt = csr_rdata_i;
      end
      ST_WRITE: w_rd_val_nxt = r_old;
      ST_RESP: begin
        if (!resp_ready_i) begin
          w_rd_val_nxt  = rd_val_o;
          w_illegal_nxt = illegal_o;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_ready_o    <= 1'b1;
      csr_read_en_o  <= 1'b0;
      csr_write_en_o <= 1'b0;
      resp_valid_o   <= 1'b0;
      csr_addr_o     <= '0;
      csr_wdata_o    <= '0;
      rd_val_o       <= '0;
      illegal_o      <= 1'b0;
    end else begin
      req_ready_o    <= w_req_ready_nxt;
      csr_read_en_o  <= w_read_en_nxt;
      csr_write_en_o <= w_write_en_nxt;
      resp_valid_o   <= w_resp_valid_nxt;
      csr_addr_o     <= w_addr_nxt;
      csr_wdata_o    <= w_wdata_nxt;
      rd_val_o       <= w_rd_val_nxt;
      illegal_o      <= w_illegal_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_funct3    <= '0;
      r_operand   <= '0;
      r_wr_intent <= 1'b0;
      r_old       <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_funct3    <= funct3_i;
        r_operand   <= w_operand;
        r_wr_intent <= w_wr_intent;
      end
      if (r_state == ST_CAPTURE) r_old <= csr_rdata_i;
    end
  end

endmodule
